// File: rtl/dcache_if.sv
// Bus bundle between the MEM stage, the data cache controller and off-chip data memory.
interface dcache_if;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;

  // Cache controller view
  modport slave (
    input  p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Pipeline plus memory view
  modport master (
    output p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Lines are 32 bytes; misses stall the pipeline until the line is resident.
module dcache_ctrl #(
  parameter int LINES = 32
) (
  input logic      clk_i,
  input logic      rst_i,
  dcache_if.slave  bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, DONE} state_t;

  state_t state, nextState;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags  [LINES];
  logic [255:0]     lines [LINES];

  logic             req;
  logic             isWrite;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] reqTag;
  logic [2:0]       word;
  logic [1:0]       unusedAddrBits;
  logic             writeHit;
  logic             wbDone;
  logic             refillDone;

  // A simultaneous read and write is resolved as a write.
  assign req            = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign isWrite        = bus.p1_MemWrite_i;
  assign word           = bus.p1_addr_i[4:2];
  assign idx            = bus.p1_addr_i[5+IDX_W-1:5];
  assign reqTag         = bus.p1_addr_i[31:5+IDX_W];
  assign unusedAddrBits = bus.p1_addr_i[1:0];
  assign hit            = valid[idx] && (tags[idx] == reqTag);

  assign writeHit   = (state == IDLE) && req && hit && isWrite;
  assign wbDone     = (state == WRITEBACK) && bus.mem_ack_i;
  assign refillDone = (state == REFILL) && bus.mem_ack_i;

  // State register plus per-line valid/dirty bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= nextState;
      if (writeHit) dirty[idx] <= 1'b1;
      if (wbDone) dirty[idx] <= 1'b0;
      if (refillDone) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (writeHit) lines[idx][{word, 5'b0} +: 32] <= bus.p1_data_i;
      if (refillDone) begin
        lines[idx] <= bus.mem_data_i;
        tags[idx]  <= reqTag;
      end
    end
  end

  // Next-state and output decode; the request is held upstream so nothing is latched.
  always_comb begin
    nextState        = state;
    bus.p1_data_o    = '0;
    bus.p1_stall_o   = req && !((state == IDLE) && hit);
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    case (state)
      IDLE: begin
        if (req && !hit) nextState = MISS;
        if (req && hit && !isWrite) bus.p1_data_o = lines[idx][{word, 5'b0} +: 32];
      end
      MISS: begin
        nextState = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {tags[idx], idx, 5'b0};
        bus.mem_data_o   = lines[idx];
        if (bus.mem_ack_i) nextState = MISS;
      end
      REFILL: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {reqTag, idx, 5'b0};
        if (bus.mem_ack_i) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

MEM-stage data cache controller for the pipelined CPU. It consumes the EX/MEM register's outputs (MemRead, MemWrite, ALU result as address, store data) and returns load data to the MEM/WB register. It is a direct-mapped, write-back, write-allocate cache of 32-byte lines in front of a slow off-chip data memory with an enable/ack handshake. On a miss it drives a stall back to the EX/MEM register's Stall_i and to the upstream stages until the line is resident.

## Interface
- LINES, 32: number of cache lines, power of two; IDX_W = log2(LINES).
- clk_i  in  1  clock; all state changes on posedge.
- rst_i  in  1  synchronous, active-high reset.
- p1_MemRead_i  in  1  load request from EX/MEM.
- p1_MemWrite_i  in  1  store request from EX/MEM.
- p1_addr_i  in  32  byte address. [4:2] selects the word, [5+IDX_W-1:5] the index, [31:5+IDX_W] the tag; [1:0] is ignored.
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data; valid only when read hit in IDLE, else 0.
- p1_stall_o  out  1  pipeline stall request.
- mem_data_i  in  256  refill line from memory, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_enable_o  out  1  memory request active.
- mem_write_o  out  1  1 = line write-back, 0 = line read.
- mem_addr_o  out  32  line address, [4:0] always 0.
- mem_data_o  out  256  victim line for write-back.

## Operation
- Storage per line: valid, dirty, tag, 256-bit data (word w at bits [32w+31:32w]).
- req = p1_MemRead_i | p1_MemWrite_i. Both high is illegal and is treated as a write.
- hit = valid[idx] & (tag[idx] == addr tag), combinational.
- States: IDLE, MISS, WRITEBACK, REFILL, DONE.
- IDLE:
  - req & hit & read: p1_data_o = selected word, same cycle, no stall.
  - req & hit & write: selected word <= p1_data_i and dirty <= 1 at posedge, no stall.
  - req & !hit: p1_stall_o = 1 combinationally, next state MISS.
- MISS (mem_enable_o = 0): if valid & dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, idx, 5'b0}, mem_data_o = victim line. Held until mem_ack_i. On ack, dirty <= 0 and next state is MISS, which gives a one-cycle enable gap before the refill.
- REFILL: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, idx, 5'b0}. Held until mem_ack_i. On ack, data <= mem_data_i, tag <= req tag, valid <= 1, dirty <= 0, next state DONE.
- DONE: stall held, next state IDLE. IDLE then re-evaluates the still-held request, which now hits. A write miss therefore merges into the refilled line there and sets dirty.
- p1_stall_o = req & !(state == IDLE & hit). It is 0 when there is no request.
- Outputs outside WRITEBACK/REFILL: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
- mem_ack_i is ignored outside WRITEBACK/REFILL.

## Timing
- Reset: state IDLE, all valid and dirty cleared, every output 0 (p1_stall_o follows req, so it is 0 with no request).
- Reset mid-transaction: state is IDLE and mem_enable_o is 0 from the next cycle. The pending memory transaction is abandoned, and a late ack is ignored.
- Hit latency: 0 cycles (combinational read; write commits at the same edge).
- Clean miss, memory ack in the L-th REFILL cycle: stall is high for 1 (IDLE) + 1 (MISS) + L + 1 (DONE) cycles. It drops in the following IDLE cycle with valid data.
- Dirty miss with write-back ack in the W-th cycle: stall is high for W + 1 additional cycles (the extra MISS).
- The upstream pipeline holds p1_* stable while p1_stall_o = 1; the block does not latch the request.

## Test plan
- After reset, read 0x0000_0040, with memory returning line words 0..7 = 0x100..0x107 and ack on the 3rd REFILL cycle. Required:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = 0x40.
  - stall high for 6 cycles.
  - p1_data_o = 0x100 in the next cycle, with stall 0.
- Read 0x44 right after → p1_data_o = 0x101 the same cycle, no stall, mem_enable_o = 0.
- Write 0x48 with 0xDEADBEEF → no stall. Then read 0x48 → 0xDEADBEEF.
- Read 0x440 (same index 2, different tag). Required:
  - WRITEBACK first: mem_write_o = 1, mem_addr_o = 0x40, mem_data_o word 2 = 0xDEADBEEF.
  - Then one cycle with enable 0.
  - Then REFILL at 0x440 and the correct load data.
- Write miss to 0x84 with 0x12345678. Required: refill of 0x80, then word 1 merged and dirty set. A later conflicting miss (0x484) writes back line 0x80 with word 1 = 0x12345678.
- Assert rst_i in the 2nd REFILL cycle. Required: mem_enable_o = 0 the next cycle, and a late ack has no effect. A subsequent read of 0x44 misses, since all lines are invalid.
